instr_encoder: RTL and testbench

Sequential RISC-V RV32I instruction encoder, the inverse of the core's instruction decoder. It accepts instruction descriptors (format class, 4-bit ALU control code, register fields, immediate) over a valid/ready stream. It emits encoded 32-bit instruction words on a write port into instruction memory, starting at a programmed base address, for a programmed number of descriptors. It sits between the test/boot loader and the instruction memory, and produces exactly the ALU control codes the decoder regenerates.

---
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns ALU-code descriptors into instruction words
// and streams them into instruction memory from a programmed base address.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_alucontrol,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting descriptors, writing legal ones
  // DONE  | one-cycle done pulse, last write visible
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              legal;
  logic [31:0]       enc;
  logic [2:0]        rf3;
  logic [6:0]        rf7;
  logic [2:0]        bf3;
  logic              rlegal;
  logic              blegal;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    rf3    = 3'b000;
    rf7    = 7'b0000000;
    rlegal = 1'b1;
    case (in_alucontrol)
      4'd0: rf3 = 3'b000;
      4'd1: begin rf3 = 3'b000; rf7 = 7'b0100000; end
      4'd2: rf3 = 3'b111;
      4'd3: rf3 = 3'b110;
      4'd4: rf3 = 3'b100;
      4'd5: rf3 = 3'b001;
      4'd6: rf3 = 3'b101;
      4'd7: begin rf3 = 3'b101; rf7 = 7'b0100000; end
      4'd8: rf3 = 3'b011;
      4'd9: rf3 = 3'b010;
      default: rlegal = 1'b0;
    endcase
  end

  always_comb begin
    bf3    = 3'b000;
    blegal = !in_imm[0];
    case (in_alucontrol)
      4'd0: bf3 = 3'b000;
      4'd1: bf3 = 3'b001;
      4'd2: bf3 = 3'b100;
      4'd3: bf3 = 3'b101;
      4'd4: bf3 = 3'b110;
      4'd5: bf3 = 3'b111;
      default: blegal = 1'b0;
    endcase
  end

  always_comb begin
    enc   = 32'd0;
    legal = 1'b1;
    case (in_class)
      2'b00: begin
        legal = rlegal;
        enc   = {rf7, in_rs2, in_rs1, rf3, in_rd, OP_R};
      end
      2'b01: begin
        // there is no subi; shifts carry funct7 in the upper immediate bits
        legal = rlegal && (in_alucontrol != 4'd1);
        if (in_alucontrol == 4'd5 || in_alucontrol == 4'd6 || in_alucontrol == 4'd7)
          enc = {rf7, in_imm[4:0], in_rs1, rf3, in_rd, OP_I};
        else
          enc = {in_imm[11:0], in_rs1, rf3, in_rd, OP_I};
      end
      2'b10: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_S};
      end
      default: begin
        legal = blegal;
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, bf3, in_imm[4:1], in_imm[11], OP_B};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      addr      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'd0;
      err_cnt   <= 8'd0;
      wrapped   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= count;
            err_cnt   <= 8'd0;
            wrapped   <= 1'b0;
            state     <= (count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1))
              state <= DONE;
            if (legal) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= enc;
              addr    <= addr + ADDR_W'(1);
              if (addr == '1)
                wrapped <= 1'b1;
            end else if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table of descriptors with
// hand-encoded words, plus sequences for reset, wrap, zero-count and ignored starts.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'd0;
  logic [7:0]  count = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_class = 2'd0;
  logic [3:0]  in_alucontrol = 4'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [12:0] in_imm = 13'd0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, wrapped;
  logic [7:0]  err_cnt;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_alucontrol(in_alucontrol), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_cnt(err_cnt), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  code;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic        legal;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[12];
  int          passed = 0;
  int          total = 0;
  logic [31:0] last_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_run(input logic [7:0] base, input int first, input int n, input logic glitch);
    logic [7:0] ea;
    int         errs;
    logic       wrap;
    ea   = base;
    errs = 0;
    wrap = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = base; count = n[7:0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = (i == 0) && glitch;
      if (glitch) begin base_addr = 8'h80; count = 8'd5; end
      in_valid      = 1'b1;
      in_class      = vecs[first+i].cls;
      in_alucontrol = vecs[first+i].code;
      in_rd         = vecs[first+i].rd;
      in_rs1        = vecs[first+i].rs1;
      in_rs2        = vecs[first+i].rs2;
      in_imm        = vecs[first+i].imm;
      check("in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("wr_en", wr_en, vecs[first+i].legal);
      if (vecs[first+i].legal) begin
        check("wr_addr", wr_addr, ea);
        check("wr_data", wr_data, vecs[first+i].data);
        last_data = vecs[first+i].data;
        if (ea == 8'hFF) wrap = 1'b1;
        ea = ea + 8'd1;
      end else begin
        errs++;
        check("wr_data_hold", wr_data, last_data);
      end
      check("busy", busy, (i < n - 1) ? 1 : 0);
      check("done", done, (i == n - 1) ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = glitch; base_addr = 8'h00; count = 8'd1;
    @(posedge clk); #1;
    check("done_drop", done, 0);
    check("busy_after", busy, 0);
    check("wr_en_after", wr_en, 0);
    check("err_cnt", err_cnt, errs);
    check("wrapped", wrapped, wrap);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen_done, seen_busy;
    vecs[0]  = '{2'b00, 4'd0,  5'd3, 5'd1, 5'd2, 13'h000, 1'b1, 32'h002081B3};
    vecs[1]  = '{2'b00, 4'd1,  5'd3, 5'd1, 5'd2, 13'h000, 1'b1, 32'h402081B3};
    vecs[2]  = '{2'b01, 4'd0,  5'd5, 5'd0, 5'd0, 13'h0FFF, 1'b1, 32'hFFF00293};
    vecs[3]  = '{2'b01, 4'd7,  5'd4, 5'd4, 5'd0, 13'h003, 1'b1, 32'h40325213};
    vecs[4]  = '{2'b10, 4'd0,  5'd0, 5'd1, 5'd2, 13'h004, 1'b1, 32'h0020A223};
    vecs[5]  = '{2'b11, 4'd0,  5'd0, 5'd1, 5'd2, 13'h008, 1'b1, 32'h00208463};
    vecs[6]  = '{2'b01, 4'd1,  5'd1, 5'd1, 5'd0, 13'h001, 1'b0, 32'h0};
    vecs[7]  = '{2'b11, 4'd6,  5'd0, 5'd1, 5'd2, 13'h008, 1'b0, 32'h0};
    vecs[8]  = '{2'b11, 4'd0,  5'd0, 5'd1, 5'd2, 13'h007, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 4'd10, 5'd1, 5'd1, 5'd2, 13'h000, 1'b0, 32'h0};
    vecs[10] = '{2'b00, 4'd2,  5'd1, 5'd2, 5'd3, 13'h000, 1'b1, 32'h003170B3};
    vecs[11] = '{2'b11, 4'd5,  5'd0, 5'd3, 5'd4, 13'h1FFE, 1'b1, 32'hFE41FFE3};

    #12;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wrapped", wrapped, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run(8'h10, 0, 1, 1'b0);
    do_run(8'h20, 1, 3, 1'b0);
    do_run(8'h30, 4, 2, 1'b0);
    do_run(8'h50, 6, 4, 1'b0);
    do_run(8'hFF, 10, 2, 1'b0);

    // zero-length run: done pulses, busy stays low, sticky status cleared
    seen_done = 1'b0;
    seen_busy = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'h33; count = 8'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("zero_done_seen", seen_done, 1);
    check("zero_busy_seen", seen_busy, 0);
    check("zero_wrapped", wrapped, 0);
    check("zero_err_cnt", err_cnt, 0);

    // start during RUN and during DONE must be ignored
    do_run(8'h40, 0, 2, 1'b1);

    // reset right after an accept drops the pending write
    @(negedge clk);
    start = 1'b1; base_addr = 8'h60; count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_class = vecs[0].cls; in_alucontrol = vecs[0].code;
    in_rd = vecs[0].rd; in_rs1 = vecs[0].rs1; in_rs2 = vecs[0].rs2; in_imm = vecs[0].imm;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_data = 32'd0;
    do_run(8'h10, 0, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
